mmio_io: RTL and testbench
==========================

# mmio_io

Parametrised memory-mapped I/O peripheral for the CPU data bus: a GPIO output register with set/clear aliases, a synchronised GPIO input port with change detection, and a free-running prescaled tick counter with a compare match. Sticky flags drive a level interrupt. It sits beside RAM and the UART in the top-level decode, with the same one-cycle registered read latency as RAM.

## Interface

- `BASE`, 30'h4100: word address of register 0; the block decodes `BASE`..`BASE+7`.
- `OUT_W`, 8: GPIO output width, 1..32.
- `IN_W`, 8: GPIO input width, 1..32.
- `CLK_HZ`, 12000000: clock frequency.
- `TICK_HZ`, 1000: tick rate. `DIV = CLK_HZ/TICK_HZ` must be an integer ≥ 2.

Ports:

- `clk` in 1: single clock. All state is updated on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `addr` in 30: word address from the CPU.
- `wdata` in 32: write data.
- `we` in 4: byte-lane write enables. `we[i]` covers `wdata[8i+7:8i]`.
- `re` in 1: read strobe.
- `hit` out 1: combinational. High when `addr` is in `BASE`..`BASE+7`.
- `rdata` out 32: registered read data.
- `gpio_in` in `IN_W`: asynchronous inputs.
- `gpio_out` out `OUT_W`: output register.
- `irq` out 1: level interrupt.

## Operation

Register map (word offset: name, access):

- 0 OUT, rw: `gpio_out`. Byte-lane writes. Bits above `OUT_W` are ignored and read as 0.
- 1 OUT_SET, w: each 1 in an enabled lane sets the matching OUT bit. Reads return OUT.
- 2 OUT_CLR, w: each 1 in an enabled lane clears the matching OUT bit. Reads return OUT.
- 3 IN, ro: synchronised input, zero-extended. Writes are ignored.
- 4 COUNT, rw: 32-bit tick count. Byte-lane writes load it and also zero the prescaler.
- 5 CMP, rw: 32-bit compare value, byte-lane writes.
- 6 STATUS, rw1c:
  - bit0 MATCH: set when COUNT increments to a value equal to CMP.
  - bit1 INCHG: set when the synchronised input differs from its previous sample.
  - Writing 1 to a bit clears it.
- 7 CTRL, rw, bits[2:0]: bit0 TEN (timer enable), bit1 MIE (match irq enable), bit2 CIE (change irq enable).

Prescaler:

- Counts 0..DIV-1 while TEN=1 and holds while TEN=0.
- On the cycle it is at DIV-1 it wraps to 0 and COUNT increments.
- COUNT wraps from 0xFFFFFFFF to 0.

Input path:

- Two-flop synchroniser, then one sample register.
- INCHG sets on any bit difference between the synchroniser output and the sample register.

Interrupt: `irq = (MATCH & MIE) | (INCHG & CIE)`, registered.

Reset values:

- OUT=0, COUNT=0, CMP=0xFFFFFFFF, STATUS=0, CTRL=3'b001 (timer running).
- Prescaler=0, synchroniser and sample registers=0, `rdata`=0, `irq`=0.

Conflict rules:

- A COUNT write in the same cycle as a tick: the write wins and no increment happens.
- A MATCH or INCHG set in the same cycle as a write-1-clear: the set wins and the flag stays 1.
- A write to COUNT or CMP never sets MATCH. Only an increment can.
- Writes with `we=0` and accesses with `hit=0` change no state.

## Timing

- Writes take effect at the edge where `we` is asserted. `gpio_out` and the register value are visible the next cycle.
- Read latency is one cycle:
  - `rdata` is loaded on the edge where `re & hit` is high.
  - It holds that value until the next read strike.
  - It is 0 after any edge with `re=1, hit=0`, so top can OR-mux it without a per-source select.
- Read and write to the same register in one cycle: `rdata` returns the old value.
- `gpio_in` to IN readable: 2 synchroniser edges, then 1 read edge. INCHG sets 3 edges after the input transition.
- Tick period is exactly DIV cycles with TEN held at 1. The first increment after reset is at edge DIV.
- MATCH sets on the same edge as the increment. `irq` rises one edge later.
- Reset asserted mid-operation clears everything immediately (asynchronous). Release is sampled on a rising `clk` edge.

## Test plan

- Reset, then read all 8 offsets:
  - Required: OUT=0, IN=0, COUNT=0, CMP=0xFFFFFFFF, STATUS=0, CTRL=1.
  - `rdata` is 0 before the first read and valid exactly one cycle after `re`.
- GPIO writes (OUT_W=8):
  - Write OUT=0x0000_00A5 with `we`=4'b1111, then OUT_SET=0x0A, then OUT_CLR=0x81. `gpio_out` must read 0xA5, then 0xAF, then 0x2E.
  - Write OUT with `we`=4'b0010: `gpio_out` unchanged.
- Timer (DIV=4):
  - Set CMP=3, MIE=1. MATCH and `irq` must rise at edges 12 and 13 after reset release.
  - Write STATUS=1 on the same edge a new match occurs: MATCH stays 1.
- COUNT and tick collision:
  - Write COUNT=0xFFFFFFFF on a tick edge: COUNT reads 0xFFFFFFFF.
  - At the next tick, COUNT=0. Set CMP=0 beforehand: MATCH sets at that wrap.
- Input change:
  - Toggle `gpio_in[3]` with CIE=1. INCHG must set 3 edges later and `irq` 4 edges later; IN reads 0x08.
  - Write STATUS=2: `irq` drops next cycle.
- Out-of-range access:
  - `re` at address `BASE+8`: `rdata`=0 next cycle and `hit`=0.
  - Write at `BASE-1`: no register changes.
  - Assert `reset` mid-tick: COUNT, `gpio_out` and `irq` are 0 immediately.

Source files
------------

// File: rtl/mmio_io.sv
// mmio_io: memory-mapped I/O peripheral on the CPU data bus.
// It provides a GPIO output register with set and clear aliases, a synchronised
// GPIO input with change detection, and a prescaled tick counter with a compare
// match. Sticky status flags drive a registered level interrupt.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   addr, wdata, we   - word address, write data, byte-lane write enables
//   re                - read strobe
//   hit               - combinational address decode of BASE..BASE+7
//   rdata             - read data, one cycle after re (0 after a missed read)
//   gpio_in           - asynchronous inputs
//   gpio_out          - output register
//   irq               - level interrupt
module mmio_io #(
    parameter logic [29:0] BASE    = 30'h4100,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned IN_W    = 8,
    parameter int unsigned CLK_HZ  = 12000000,
    parameter int unsigned TICK_HZ = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [29:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [3:0]       we,
    input  logic             re,
    output logic             hit,
    output logic [31:0]      rdata,
    input  logic [IN_W-1:0]  gpio_in,
    output logic [OUT_W-1:0] gpio_out,
    output logic             irq
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);

    localparam logic [2:0] OFF_OUT    = 3'd0;
    localparam logic [2:0] OFF_SET    = 3'd1;
    localparam logic [2:0] OFF_CLR    = 3'd2;
    localparam logic [2:0] OFF_IN     = 3'd3;
    localparam logic [2:0] OFF_COUNT  = 3'd4;
    localparam logic [2:0] OFF_CMP    = 3'd5;
    localparam logic [2:0] OFF_STATUS = 3'd6;
    localparam logic [2:0] OFF_CTRL   = 3'd7;

    logic [OUT_W-1:0] out_q,    out_d;
    logic [31:0]      count_q,  count_d;
    logic [31:0]      cmp_q,    cmp_d;
    logic [1:0]       status_q, status_d;
    logic [2:0]       ctrl_q,   ctrl_d;
    logic [PW-1:0]    presc_q,  presc_d;
    logic [IN_W-1:0]  sync1_q, sync2_q, samp_q;
    logic [31:0]      rdata_q;
    logic             irq_q;

    logic [29:0] rel;
    logic [2:0]  off;
    logic [31:0] wmask;
    logic [31:0] out_ext;
    logic [31:0] count_inc;
    logic [31:0] rd_val;
    logic        tick;
    logic        count_wr;
    logic [1:0]  status_set;
    logic [1:0]  status_clr;

    // Address decode: subtraction wraps addresses below BASE to large values
    assign rel = addr - BASE;
    assign hit = (rel < 30'd8);
    assign off = rel[2:0];

    assign wmask     = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    assign out_ext   = 32'(out_q);
    assign count_inc = count_q + 32'd1;
    assign tick      = ctrl_q[0] && (presc_q == PW'(DIV - 1));
    assign count_wr  = hit && (off == OFF_COUNT) && (we != 4'd0);

    // Flag set sources; a COUNT write suppresses the increment and so the match
    assign status_set[0] = tick && !count_wr && (count_inc == cmp_q);
    assign status_set[1] = (sync2_q != samp_q);
    assign status_clr    = (hit && (off == OFF_STATUS)) ? (wdata[1:0] & {2{we[0]}}) : 2'b00;

    // Next-state for the register file, prescaler and counter
    always_comb begin
        out_d    = out_q;
        count_d  = count_q;
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;
        status_d = (status_q & ~status_clr) | status_set;

        if (ctrl_q[0]) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                count_d = count_inc;
            end
        end

        if (hit) begin
            unique case (off)
                OFF_OUT: out_d = OUT_W'((out_ext & ~wmask) | (wdata & wmask));
                OFF_SET: out_d = OUT_W'(out_ext | (wdata & wmask));
                OFF_CLR: out_d = OUT_W'(out_ext & ~(wdata & wmask));
                OFF_COUNT: begin
                    if (count_wr) begin
                        count_d = (count_q & ~wmask) | (wdata & wmask);
                        presc_d = '0;
                    end
                end
                OFF_CMP:  cmp_d = (cmp_q & ~wmask) | (wdata & wmask);
                OFF_CTRL: begin
                    if (we[0]) begin
                        ctrl_d = wdata[2:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Read mux; SET/CLR aliases read back the OUT register
    always_comb begin
        rd_val = 32'd0;
        unique case (off)
            OFF_OUT, OFF_SET, OFF_CLR: rd_val = out_ext;
            OFF_IN:     rd_val = 32'(sync2_q);
            OFF_COUNT:  rd_val = count_q;
            OFF_CMP:    rd_val = cmp_q;
            OFF_STATUS: rd_val = 32'(status_q);
            OFF_CTRL:   rd_val = 32'(ctrl_q);
            default:    rd_val = 32'd0;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q    <= '0;
            count_q  <= 32'd0;
            cmp_q    <= 32'hFFFF_FFFF;
            status_q <= 2'b00;
            ctrl_q   <= 3'b001;
            presc_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            samp_q   <= '0;
            rdata_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            count_q  <= count_d;
            cmp_q    <= cmp_d;
            status_q <= status_d;
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            sync1_q  <= gpio_in;
            sync2_q  <= sync1_q;
            samp_q   <= sync2_q;
            irq_q    <= (status_q[0] & ctrl_q[1]) | (status_q[1] & ctrl_q[2]);
            // Missed reads return 0 so the top level can OR-combine sources
            if (re) begin
                rdata_q <= hit ? rd_val : 32'd0;
            end
        end
    end

    assign rdata    = rdata_q;
    assign gpio_out = out_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_io.sv
// Directed bench for mmio_io with DIV = 4 and 8-bit GPIO.
module tb_mmio_io;

    localparam logic [29:0] BASE = 30'h4100;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic        hit;
    logic [31:0] rdata;
    logic [7:0]  gpio_in;
    logic [7:0]  gpio_out;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    mmio_io #(
        .BASE    (BASE),
        .OUT_W   (8),
        .IN_W    (8),
        .CLK_HZ  (4000),
        .TICK_HZ (1000)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .hit      (hit),
        .rdata    (rdata),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each bus task consumes one rising edge and returns on the following falling edge
    task automatic wr_raw(input logic [29:0] a, input logic [31:0] d, input logic [3:0] w);
        addr = a; wdata = d; we = w;
        @(posedge clk);
        @(negedge clk);
        we = 4'd0;
    endtask

    task automatic wr(input logic [2:0] o, input logic [31:0] d, input logic [3:0] w);
        wr_raw(BASE + 30'(o), d, w);
    endtask

    task automatic rd(input logic [2:0] o);
        addr = BASE + 30'(o); re = 1'b1;
        @(posedge clk);
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Release lands on a falling edge so the next rising edge is edge 1
    task automatic do_reset();
        reset = 1'b0; we = 4'd0; re = 1'b0; gpio_in = 8'd0;
        addr = BASE; wdata = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; addr = BASE; wdata = 32'd0; we = 4'd0; re = 1'b0; gpio_in = 8'd0;

        // Reset values; COUNT read first before the first tick at edge 4
        do_reset();
        chk("rdata_pre_read", rdata, 32'd0);
        chk("irq_reset", 32'(irq), 32'd0);
        chk("gpio_out_reset", 32'(gpio_out), 32'd0);
        rd(3'd4); chk("rst_count", rdata, 32'd0);
        rd(3'd0); chk("rst_out", rdata, 32'd0);
        rd(3'd1); chk("rst_out_set", rdata, 32'd0);
        rd(3'd2); chk("rst_out_clr", rdata, 32'd0);
        rd(3'd3); chk("rst_in", rdata, 32'd0);
        rd(3'd5); chk("rst_cmp", rdata, 32'hFFFF_FFFF);
        rd(3'd6); chk("rst_status", rdata, 32'd0);
        rd(3'd7); chk("rst_ctrl", rdata, 32'd1);
        idle(2);  chk("rdata_hold", rdata, 32'd1);

        // GPIO output register and aliases
        do_reset();
        wr(3'd0, 32'h0000_00A5, 4'b1111); chk("out_write", 32'(gpio_out), 32'hA5);
        wr(3'd1, 32'h0000_000A, 4'b1111); chk("out_set", 32'(gpio_out), 32'hAF);
        wr(3'd2, 32'h0000_0081, 4'b1111); chk("out_clr", 32'(gpio_out), 32'h2E);
        wr(3'd0, 32'hFFFF_FFFF, 4'b0010); chk("out_lane1_only", 32'(gpio_out), 32'h2E);
        rd(3'd1);                         chk("rd_out_set_alias", rdata, 32'h2E);
        wr(3'd0, 32'h1234_5633, 4'b0001); chk("out_lane0", 32'(gpio_out), 32'h33);
        rd(3'd0);                         chk("rd_out", rdata, 32'h33);

        // Timer: edges counted from reset release, ticks at 4, 8, 12, ...
        do_reset();
        wr(3'd5, 32'd3, 4'b1111);          // e1: CMP = 3
        wr(3'd7, 32'd3, 4'b1111);          // e2: TEN | MIE
        idle(8);                           // e3..e10
        rd(3'd6);                          // e11
        chk("tmr_status_e11", rdata, 32'd0);
        chk("tmr_irq_e11", 32'(irq), 32'd0);
        idle(1);                           // e12: MATCH sets
        chk("tmr_irq_e12", 32'(irq), 32'd0);
        rd(3'd6);                          // e13
        chk("tmr_status_e13", rdata, 32'd1);
        chk("tmr_irq_e13", 32'(irq), 32'd1);
        wr(3'd5, 32'd4, 4'b1111);          // e14: CMP = 4
        idle(1);                           // e15
        wr(3'd6, 32'd1, 4'b1111);          // e16: clear collides with match
        rd(3'd6);                          // e17
        chk("set_wins_over_clear", rdata, 32'd1);
        wr(3'd6, 32'd1, 4'b1111);          // e18: plain clear
        rd(3'd6);                          // e19
        chk("status_cleared", rdata, 32'd0);
        chk("irq_after_clear", 32'(irq), 32'd0);

        // COUNT write on a tick edge, then wrap to 0 matching CMP = 0
        wr(3'd5, 32'd0, 4'b1111);          // e20 (tick)
        idle(3);                           // e21..e23
        wr(3'd4, 32'hFFFF_FFFF, 4'b1111);  // e24: tick edge, write wins
        rd(3'd4);                          // e25
        chk("count_write_wins", rdata, 32'hFFFF_FFFF);
        rd(3'd6);                          // e26
        chk("no_match_on_write", rdata, 32'd0);
        idle(2);                           // e27, e28 (tick, wrap)
        rd(3'd4);                          // e29
        chk("count_wrap", rdata, 32'd0);
        rd(3'd6);                          // e30
        chk("match_at_wrap", rdata, 32'd1);

        // Input change detection with the timer stopped
        do_reset();
        wr(3'd7, 32'd4, 4'b1111);          // CIE only
        gpio_in = 8'h08;
        idle(2);
        chk("inchg_irq_2", 32'(irq), 32'd0);
        rd(3'd3);                          // third edge: INCHG sets
        chk("in_value", rdata, 32'h08);
        chk("inchg_irq_3", 32'(irq), 32'd0);
        rd(3'd6);                          // fourth edge: irq rises
        chk("inchg_status", rdata, 32'd2);
        chk("inchg_irq_4", 32'(irq), 32'd1);
        wr(3'd6, 32'd2, 4'b1111);
        idle(1);
        chk("inchg_irq_drop", 32'(irq), 32'd0);
        rd(3'd4);
        chk("count_held_ten0", rdata, 32'd0);

        // Out-of-range accesses
        do_reset();
        wr(3'd0, 32'h5A, 4'b1111);
        rd(3'd0);
        chk("rd_before_miss", rdata, 32'h5A);
        addr = BASE + 30'd8; re = 1'b1;
        #1 chk("hit_base_p8", 32'(hit), 32'd0);
        @(posedge clk);
        @(negedge clk);
        re = 1'b0;
        chk("rdata_miss_zero", rdata, 32'd0);
        addr = BASE + 30'd7;
        #1 chk("hit_base_p7", 32'(hit), 32'd1);
        addr = BASE;
        #1 chk("hit_base", 32'(hit), 32'd1);
        addr = BASE - 30'd1;
        #1 chk("hit_base_m1", 32'(hit), 32'd0);
        @(negedge clk);
        wr_raw(BASE - 30'd1, 32'hFFFF_FFFF, 4'b1111);
        chk("miss_wr_out", 32'(gpio_out), 32'h5A);
        rd(3'd5); chk("miss_wr_cmp", rdata, 32'hFFFF_FFFF);
        rd(3'd7); chk("miss_wr_ctrl", rdata, 32'd1);

        // Asynchronous reset in the middle of a tick period
        do_reset();
        wr(3'd0, 32'hFF, 4'b1111);         // e1
        wr(3'd5, 32'd1, 4'b1111);          // e2
        wr(3'd7, 32'd3, 4'b1111);          // e3
        idle(2);                           // e4 match, e5 irq
        chk("pre_reset_irq", 32'(irq), 32'd1);
        chk("pre_reset_out", 32'(gpio_out), 32'hFF);
        idle(1);                           // e6: prescaler mid-period
        #2 reset = 1'b0;
        #1;
        chk("async_rst_out", 32'(gpio_out), 32'd0);
        chk("async_rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd(3'd4);
        chk("async_rst_count", rdata, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
